// File: rtl/issue_exe_lane_reg.sv
// Issue->EXE pipeline register: accepts an in-order prefix of up to LANES
// decoded instructions, steers the single special instruction to
// SPECIAL_LANE, and registers payload/PC/age/branch-prediction into EX.
module issue_exe_lane_reg #(
    parameter int LANES        = 2,
    parameter int PAYLOAD_W    = 128,
    parameter int SPECIAL_LANE = 1,
    parameter int ZERO_INVALID = 1,
    localparam int AGE_W       = $clog2(LANES),
    localparam int CNT_W       = $clog2(LANES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES-1:0]           in_special,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    input  logic [LANES*32-1:0]        in_pc,
    input  logic [LANES*32-1:0]        in_pc_pre,
    output logic [CNT_W-1:0]           in_accept_cnt,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    output logic [LANES*32-1:0]        out_pc,
    output logic [LANES*32-1:0]        out_pc_pre,
    output logic [LANES-1:0]           out_br_pd,
    output logic [LANES*AGE_W-1:0]     out_age
);

    // Handshake: in_valid is a prefix mask offered by the issue buffer; the
    // buffer pops exactly in_accept_cnt entries (oldest first) at the next
    // rising edge. There is no ready path back from EXE: stall holds EX,
    // flush empties it, and both force in_accept_cnt to 0.

    logic [CNT_W-1:0]                  n;
    logic [CNT_W-1:0]                  k;
    logic [CNT_W-1:0]                  s2;
    logic                              seen_one;
    logic                              seen_two;
    logic                              has_special;
    logic [CNT_W-1:0]                  ptr;
    logic [LANES-1:0][CNT_W-1:0]       dst;

    logic [LANES-1:0]                  valid_d, valid_q;
    logic [LANES-1:0]                  br_pd_d, br_pd_q;
    logic [LANES-1:0][AGE_W-1:0]       age_d, age_q;
    logic [LANES-1:0][PAYLOAD_W-1:0]   payload_d, payload_q;
    logic [LANES-1:0][31:0]            pc_d, pc_q;
    logic [LANES-1:0][31:0]            pc_pre_d, pc_pre_q;

    // Acceptance count: whole valid prefix, cut before the second special.
    always_comb begin
        k        = '0;
        s2       = '0;
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
                k = k + CNT_W'(1);
            end
            if (in_valid[i] && in_special[i]) begin
                if (seen_one && !seen_two) begin
                    seen_two = 1'b1;
                    s2       = CNT_W'(i);
                end
                seen_one = 1'b1;
            end
        end
        n = seen_two ? s2 : k;
        if (rst || flush || stall) begin
            n = '0;
        end
    end

    assign in_accept_cnt = n;

    // Steering: destination lane for each accepted age. The special (at most
    // one after the cut) takes SPECIAL_LANE; the rest fill ascending lanes.
    always_comb begin
        has_special = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < n && in_special[i]) begin
                has_special = 1'b1;
            end
        end
        ptr = '0;
        dst = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < n) begin
                if (has_special && in_special[i]) begin
                    dst[i] = CNT_W'(SPECIAL_LANE);
                end else begin
                    if (has_special && ptr == CNT_W'(SPECIAL_LANE)) begin
                        ptr = ptr + CNT_W'(1);
                    end
                    dst[i] = ptr;
                    ptr    = ptr + CNT_W'(1);
                end
            end
        end
    end

    // Next EX contents: flush empties, stall holds, otherwise load the bundle.
    always_comb begin
        valid_d   = valid_q;
        br_pd_d   = br_pd_q;
        age_d     = age_q;
        payload_d = payload_q;
        pc_d      = pc_q;
        pc_pre_d  = pc_pre_q;
        if (flush) begin
            valid_d = '0;
            br_pd_d = '0;
            age_d   = '0;
            if (ZERO_INVALID != 0) begin
                payload_d = '0;
                pc_d      = '0;
                pc_pre_d  = '0;
            end
        end else if (!stall) begin
            valid_d = '0;
            br_pd_d = '0;
            age_d   = '0;
            if (ZERO_INVALID != 0) begin
                payload_d = '0;
                pc_d      = '0;
                pc_pre_d  = '0;
            end
            for (int j = 0; j < LANES; j++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (CNT_W'(i) < n && dst[i] == CNT_W'(j)) begin
                        valid_d[j]   = 1'b1;
                        age_d[j]     = AGE_W'(i);
                        payload_d[j] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
                        pc_d[j]      = in_pc[i*32 +: 32];
                        pc_pre_d[j]  = in_pc_pre[i*32 +: 32];
                        br_pd_d[j]   = (in_pc_pre[i*32 +: 32] != in_pc[i*32 +: 32] + 32'd4);
                    end
                end
            end
        end
    end

    // EX register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            br_pd_q   <= '0;
            age_q     <= '0;
            payload_q <= '0;
            pc_q      <= '0;
            pc_pre_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            br_pd_q   <= br_pd_d;
            age_q     <= age_d;
            payload_q <= payload_d;
            pc_q      <= pc_d;
            pc_pre_q  <= pc_pre_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_br_pd   = br_pd_q;
    assign out_age     = age_q;
    assign out_payload = payload_q;
    assign out_pc      = pc_q;
    assign out_pc_pre  = pc_pre_q;

endmodule
